// File: rtl/rns_mac_64.sv
// Multiply-accumulate engine over a 9-channel residue number system.
// Channel 0 is mod 2 (one bit); channels 1..8 are 8-bit pairwise-coprime moduli.
module rns_mac_64 #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [64:0]      a_rns,
    input  logic [64:0]      b_rns,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [64:0]      out_rns,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_ZERO = LEN_W'(0);

    // Moduli of channels 1..8; their product with 2 exceeds 2**64.
    function automatic logic [7:0] modulus(input int ch);
        logic [7:0] m;
        case (ch)
            1:       m = 8'd255;
            2:       m = 8'd253;
            3:       m = 8'd251;
            4:       m = 8'd247;
            5:       m = 8'd241;
            6:       m = 8'd239;
            7:       m = 8'd233;
            8:       m = 8'd229;
            default: m = 8'd255;
        endcase
        return m;
    endfunction

    function automatic logic [7:0] mod_acc(input logic [7:0] acc, input logic [15:0] p,
                                           input logic [7:0] m);
        logic [7:0] r;
        logic [8:0] s;
        r = 8'(p % {8'd0, m});
        s = {1'b0, acc} + {1'b0, r};
        if (s >= {1'b0, m}) begin
            return 8'(s - {1'b0, m});
        end else begin
            return s[7:0];
        end
    endfunction

    state_t           state_r, state_next_s;
    logic [LEN_W-1:0] len_r, cnt_r;
    logic             in_ready_r, out_valid_r, busy_r;
    logic             p_vld_r, p0_r, acc0_r;
    logic [15:0]      p_r   [1:8];
    logic [7:0]       acc_r [1:8];
    logic             xfer_s, last_s, clr_s;

    assign xfer_s = in_valid & in_ready_r;
    assign last_s = (cnt_r == (len_r - LEN_ONE));
    assign clr_s  = (state_r == IDLE) & start;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = (len != LEN_ZERO) ? ACCUM : DONE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACCUM: begin
                if (xfer_s && last_s) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = ACCUM;
                end
            end
            DRAIN:   state_next_s = DONE;
            DONE: begin
                if (out_valid_r && out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Handshake/status flags registered from the next state so they align with state_r.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            in_ready_r  <= (state_next_s == ACCUM);
            out_valid_r <= (state_next_s == DONE);
            busy_r      <= (state_next_s != IDLE);
        end
    end

    // Term length latch and transfer counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_r <= LEN_ZERO;
            cnt_r <= LEN_ZERO;
        end else if (clr_s) begin
            len_r <= len;
            cnt_r <= LEN_ZERO;
        end else if (xfer_s) begin
            cnt_r <= cnt_r + LEN_ONE;
        end
    end

    // Stage 1: per-channel raw products of the accepted pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_vld_r <= 1'b0;
            p0_r    <= 1'b0;
            for (int i = 1; i <= 8; i++) p_r[i] <= 16'd0;
        end else begin
            p_vld_r <= xfer_s;
            if (xfer_s) begin
                p0_r <= a_rns[0] & b_rns[0];
                for (int i = 1; i <= 8; i++) p_r[i] <= 16'(a_rns[8*i -: 8]) * 16'(b_rns[8*i -: 8]);
            end
        end
    end

    // Stage 2: reduce each product and add it modulo the channel modulus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc0_r <= 1'b0;
            for (int i = 1; i <= 8; i++) acc_r[i] <= 8'd0;
        end else if (clr_s) begin
            acc0_r <= 1'b0;
            for (int i = 1; i <= 8; i++) acc_r[i] <= 8'd0;
        end else if (p_vld_r) begin
            acc0_r <= acc0_r ^ p0_r;
            for (int i = 1; i <= 8; i++) acc_r[i] <= mod_acc(acc_r[i], p_r[i], modulus(i));
        end
    end

    assign out_rns[0] = acc0_r;
    for (genvar g = 1; g <= 8; g++) begin : g_out
        assign out_rns[8*g -: 8] = acc_r[g];
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_rns_mac_64.sv
// Self-checking bench for rns_mac_64: vector table, corner sequences and random ops,
// with expected residues queued when an operation is started.
module tb_rns_mac_64;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic        in_ready;
    logic [64:0] a_rns, b_rns;
    logic        out_valid;
    logic        out_ready;
    logic [64:0] out_rns;
    logic        busy;

    rns_mac_64 #(.LEN_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_rns(a_rns), .b_rns(b_rns),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rns(out_rns), .busy(busy)
    );

    always #5 clk = ~clk;

    int mods [9] = '{2, 255, 253, 251, 247, 241, 239, 233, 229};

    typedef struct {
        int          n;
        longint      a [4];
        longint      b [4];
        logic [7:0]  vpat;
        int          hold;
        longint      exp;
    } vec_t;

    vec_t          tbl [6];
    longint        op_a [256];
    longint        op_b [256];
    logic [64:0]   sb_q [$];
    int            total = 0;
    int            passed = 0;

    function automatic logic [64:0] to_rns(input longint x);
        logic [64:0] r;
        longint m, q;
        r = '0;
        for (int i = 0; i < 9; i++) begin
            m = longint'(mods[i]);
            q = x % m;
            if (q < 0) q = q + m;
            if (i == 0) r[0] = q[0];
            else r[8*i -: 8] = q[7:0];
        end
        return r;
    endfunction

    // Channel-wise residue accumulation, used for operands whose true sum exceeds 64 bits.
    function automatic logic [64:0] rns_step(input logic [64:0] acc, input longint a, input longint b);
        logic [64:0] ra, rb, r;
        longint s;
        ra = to_rns(a);
        rb = to_rns(b);
        r = '0;
        r[0] = acc[0] ^ (ra[0] & rb[0]);
        for (int i = 1; i < 9; i++) begin
            s = (longint'(acc[8*i -: 8]) + longint'(ra[8*i -: 8]) * longint'(rb[8*i -: 8])) % longint'(mods[i]);
            r[8*i -: 8] = s[7:0];
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic set_vec(input int idx, input int n, input longint a0, a1, a2, a3,
                           input longint b0, b1, b2, b3, input logic [7:0] vpat,
                           input int hold, input longint exp);
        tbl[idx].n = n;
        tbl[idx].a[0] = a0; tbl[idx].a[1] = a1; tbl[idx].a[2] = a2; tbl[idx].a[3] = a3;
        tbl[idx].b[0] = b0; tbl[idx].b[1] = b1; tbl[idx].b[2] = b2; tbl[idx].b[3] = b3;
        tbl[idx].vpat = vpat;
        tbl[idx].hold = hold;
        tbl[idx].exp  = exp;
    endtask

    task automatic do_start(input int n);
        @(negedge clk);
        start = 1'b1;
        len   = n[7:0];
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offers op_a/op_b pairs; returns at the negedge after the final transfer edge.
    task automatic feed(input int n, input logic [7:0] vpat, input bit randgap);
        int k = 0;
        int cyc = 0;
        while (k < n && cyc < 4000) begin
            if (randgap) in_valid = ($urandom_range(0, 3) != 0);
            else if (cyc < 8) in_valid = vpat[cyc[2:0]];
            else in_valid = 1'b1;
            a_rns = to_rns(op_a[k]);
            b_rns = to_rns(op_b[k]);
            if (in_valid && in_ready) k++;
            cyc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (k < n) chk("feed_timeout", 65'(k), 65'(n));
    endtask

    task automatic do_op(input int n, input logic [7:0] vpat, input bit randgap, input int hold);
        logic [64:0] e;
        do_start(n);
        if (n > 0) begin
            feed(n, vpat, randgap);
            chk("in_ready_drop", 65'(in_ready), 65'(0));
            chk("drain_no_valid", 65'(out_valid), 65'(0));
            @(negedge clk);
        end
        chk("out_valid_latency", 65'(out_valid), 65'(1));
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 65'(0), 65'(1));
            e = '0;
        end else begin
            e = sb_q.pop_front();
        end
        chk("result", out_rns, e);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 65'(out_valid), 65'(1));
            chk("hold_result", out_rns, e);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle_busy", 65'(busy), 65'(0));
    endtask

    initial begin
        logic [64:0] e;
        longint      s;
        int          n;
        rst = 1'b1; start = 1'b0; len = 8'd0; in_valid = 1'b0;
        a_rns = '0; b_rns = '0; out_ready = 1'b0;

        set_vec(0, 1, 3, 0, 0, 0, 5, 0, 0, 0, 8'hff, 0, 15);
        set_vec(1, 4, 2, 4, -1, 10, 3, 5, 7, 10, 8'hff, 0, 119);
        set_vec(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'hff, 0, 0);
        set_vec(3, 1, 3, 0, 0, 0, 5, 0, 0, 0, 8'hff, 5, 15);
        set_vec(4, 3, 7, 7, 7, 0, -6, -6, -6, 0, 8'b0010_1001, 0, -126);
        set_vec(5, 3, -5, 100, 0, 0, -5, -3, 9, 0, 8'b0000_0101, 1, -275);

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 65'(in_ready), 65'(0));
        chk("rst_out_valid", 65'(out_valid), 65'(0));
        chk("rst_busy", 65'(busy), 65'(0));
        chk("rst_out_rns", out_rns, 65'(0));
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            for (int k = 0; k < 4; k++) begin
                op_a[k] = tbl[v].a[k];
                op_b[k] = tbl[v].b[k];
            end
            sb_q.push_back(to_rns(tbl[v].exp));
            do_op(tbl[v].n, tbl[v].vpat, 1'b0, tbl[v].hold);
        end

        // len=0 with a second start while the result is waiting, then start during the handshake.
        do_start(0);
        chk("len0_valid", 65'(out_valid), 65'(1));
        chk("len0_result", out_rns, 65'(0));
        start = 1'b1; len = 8'd5;
        @(negedge clk);
        chk("restart_ignored_valid", 65'(out_valid), 65'(1));
        chk("restart_ignored_ready", 65'(in_ready), 65'(0));
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; out_ready = 1'b0;
        chk("start_at_handshake_busy", 65'(busy), 65'(0));
        chk("start_at_handshake_ready", 65'(in_ready), 65'(0));

        // Abort after two of four transfers; the partial sum must vanish at once.
        op_a[0] = 2; op_b[0] = 3; op_a[1] = 4; op_b[1] = 5;
        do_start(4);
        feed(2, 8'hff, 1'b0);
        @(negedge clk);
        chk("partial_sum", out_rns, to_rns(26));
        rst = 1'b1;
        #1;
        chk("abort_in_ready", 65'(in_ready), 65'(0));
        chk("abort_out_valid", 65'(out_valid), 65'(0));
        chk("abort_busy", 65'(busy), 65'(0));
        chk("abort_out_rns", out_rns, 65'(0));
        @(negedge clk);
        rst = 1'b0;
        op_a[0] = 1; op_b[0] = 1; op_a[1] = 2; op_b[1] = 2;
        sb_q.push_back(to_rns(5));
        do_op(2, 8'hff, 1'b0, 0);

        // Random operations: even ones against an exact integer sum, odd ones full 64-bit.
        for (int r = 0; r < 60; r++) begin
            n = $urandom_range(1, 255);
            s = 0;
            e = '0;
            for (int k = 0; k < n; k++) begin
                if (r % 2 == 0) begin
                    op_a[k] = longint'($urandom_range(0, 33554431)) - 64'sd16777216;
                    op_b[k] = longint'($urandom_range(0, 33554431)) - 64'sd16777216;
                    s = s + op_a[k] * op_b[k];
                end else begin
                    op_a[k] = {$urandom, $urandom};
                    op_b[k] = {$urandom, $urandom};
                    e = rns_step(e, op_a[k], op_b[k]);
                end
            end
            if (r % 2 == 0) e = to_rns(s);
            sb_q.push_back(e);
            do_op(n, 8'hff, 1'b1, $urandom_range(0, 2));
        end

        chk("scoreboard_drained", 65'(sb_q.size()), 65'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
